led_seq_ctrl: RTL
=================

# led_seq_ctrl

LED sequencing controller for the Tiny Tapeout LED top level. It owns the free-running prescaler that paces the visible LEDs and accepts mode/rate/pattern configuration over a valid/ready handshake. It drives the LED bank through four modes: off, blink, chase and PWM breathe. It sits between the `ui_in` configuration decode and `uo_out`.

## Interface
- `PRESC_W`, 24: prescaler width; one tick every 2^PRESC_W clocks; minimum 4.
- `NUM_LED`, 8: LED bank width.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  controller can accept configuration.
- `cfg_mode`  in  2  0 OFF, 1 BLINK, 2 CHASE, 3 BREATHE.
- `cfg_rate`  in  3  one step every 2^cfg_rate ticks.
- `cfg_pattern`  in  NUM_LED  LED pattern / chase seed.
- `led`  out  NUM_LED  registered LED drive.
- `busy`  out  1  high whenever state is not IDLE.
- `step_tick`  out  1  one-clock pulse on every pattern step.

## Operation
- **Prescaler**
  - PRESC_W-bit up-counter; wraps all-ones to 0.
  - `tick` is asserted in the cycle the count is all-ones.
  - `pwm_cnt` = prescaler[3:0].
  - The prescaler is never cleared by configuration, only by reset.
- **Step counter**
  - 7 bits; advances on `tick`.
  - A step fires when `tick` and step_cnt == 2^rate−1; step_cnt then returns to 0.
- **FSM states**
  - IDLE: mode OFF, `led`=0. Goes to APPLY on handshake.
  - APPLY: exactly one cycle. Loads the config registers, clears step_cnt and brightness, sets direction to up. Goes to IDLE if the mode is OFF, otherwise to RUN.
  - RUN: steps the active mode. Goes to APPLY on handshake.
- **Handshake**
  - Transfer occurs when `cfg_valid & cfg_ready`.
  - `cfg_ready` = 0 only in APPLY.
  - Inputs are sampled at the transfer edge only; `cfg_valid` may stay high for back-to-back transfers.
- **LED value loaded at APPLY**
  - OFF and BREATHE: 0.
  - BLINK and CHASE: pattern.
- **Per-step behaviour in RUN**
  - BLINK: `led` alternates pattern ↔ 0.
  - CHASE: `led` rotates left by 1; MSB wraps to bit 0.
  - BREATHE: brightness (4 bits) steps ±1. Direction flips to down on reaching 15 and to up on reaching 0, so the sequence is 0,1,…,15,14,…,0,1.
- **BREATHE output**
  - `led` is updated every clock, not only on steps.
  - `led` = pattern when pwm_cnt < brightness, else 0.
  - Brightness 0 → always off; brightness 15 → 15/16 duty.
- **Edge cases**
  - A pattern of 0 keeps `led` at 0 in every mode.
  - A tick or step coinciding with APPLY is dropped. The first step after APPLY occurs at the next qualifying tick.
- **`step_tick`** pulses in RUN only, in the cycle the step takes effect in `led`.

## Timing
- **Reset values**
  - State IDLE.
  - `led`=0 (see Configuration).
  - `cfg_ready`=1, `busy`=0, `step_tick`=0.
  - Prescaler, step_cnt and brightness all 0.
  - Config registers: mode OFF, rate 0, pattern 0.
- **Latency:** handshake at edge k → APPLY during cycle k..k+1 → new `led` visible after edge k+1.
- **Reset mid-operation:** a low `rst_n` at any edge, including during APPLY, forces all reset values at that edge. Handshakes in that cycle are ignored.
- **Step period:** 2^(PRESC_W+rate) clocks once in RUN.

## Configuration
- `LED_SEQ_ACTIVE_LOW_EN`
  - Defined: `led` is driven inverted for active-low boards; reset value and OFF value are all ones. Internal state is unchanged.
  - Undefined: active-high as described above.

## Structure
- **Package `led_seq_pkg`**
  - Mode enum: MODE_OFF, MODE_BLINK, MODE_CHASE, MODE_BREATHE.
  - State enum: ST_IDLE, ST_APPLY, ST_RUN.
  - Constants PWM_BITS=4 and RATE_W=3.
- **Sub-module `led_seq_prescaler`:** counter, `tick` and `pwm_cnt`, parameterised by PRESC_W. The FSM, step logic and LED datapath stay in `led_seq_ctrl`.

## Test plan
All scenarios use PRESC_W=4 (tick every 16 clocks).
- **Reset:** `rst_n` low for 2 clocks → `led`=0, `cfg_ready`=1, `busy`=0. No `step_tick` over 100 clocks.
- **BLINK:** mode 1, rate 0, pattern 0xA5 → `led`=0xA5 one clock after handshake. Then 0x00 and 0xA5 alternate every 16 clocks, with a `step_tick` at each change.
- **CHASE:** mode 2, rate 1, pattern 0x81 → `led` goes 0x81, 0x03, 0x06 at 32-clock spacing. After 8 steps it returns to 0x81.
- **BREATHE:** mode 3, rate 0, pattern 0xFF.
  - Brightness reaches 15 after 15 steps, then falls.
  - With brightness 4, `led`=0xFF for exactly 4 of each 16 clocks.
- **Back-to-back configuration:** `cfg_valid` held high for 2 transfers → `cfg_ready` low one clock between them; the second config wins. Mode 0 → `busy` falls and `led`=0.
- **Reset during APPLY:** assert `rst_n` low in the APPLY cycle → all reset values on the next clock; the pending config is discarded.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencing controller.
// Contents:
//   mode_t      - configured LED mode (OFF, BLINK, CHASE, BREATHE)
//   state_t     - controller state (IDLE, APPLY, RUN)
//   PWM_BITS    - width of the breathe brightness and PWM phase
//   RATE_W      - width of the step-rate exponent
//   STEP_W      - width of the tick-to-step counter
//   step_limit  - terminal step_cnt value for a given rate (2^rate - 1)
package led_seq_pkg;

    localparam int PWM_BITS = 4;
    localparam int RATE_W   = 3;
    localparam int STEP_W   = 7;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic logic [STEP_W-1:0] step_limit(input logic [RATE_W-1:0] rate);
        logic [STEP_W:0] span;
        span = (STEP_W + 1)'(1) << rate;
        return STEP_W'(span - (STEP_W + 1)'(1));
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Configuration handshake bundle for led_seq_ctrl.
// Signals:
//   cfg_valid   - configuration offered (master -> slave)
//   cfg_ready   - controller can accept configuration (slave -> master)
//   cfg_mode    - 0 OFF, 1 BLINK, 2 CHASE, 3 BREATHE
//   cfg_rate    - one step every 2^cfg_rate prescaler ticks
//   cfg_pattern - LED pattern / chase seed
// Modports: master (configuration source), slave (the controller).
interface led_seq_ctrl_if #(
    parameter int NUM_LED = 8
) ();
    import led_seq_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_mode;
    logic [RATE_W-1:0]  cfg_rate;
    logic [NUM_LED-1:0] cfg_pattern;

    modport master (
        output cfg_valid,
        output cfg_mode,
        output cfg_rate,
        output cfg_pattern,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        input  cfg_rate,
        input  cfg_pattern,
        output cfg_ready
    );

endinterface

// File: rtl/led_seq_prescaler.sv
// Free-running prescaler pacing the LED sequencer.
// Parameters:
//   PRESC_W - counter width; one tick every 2^PRESC_W clocks (minimum 4)
// Ports:
//   clk     - system clock
//   rst_n   - synchronous active-low reset (clears the counter)
//   tick    - high in the cycle the counter is all ones
//   pwm_cnt - low PWM_BITS of the counter, used as the breathe PWM phase
module led_seq_prescaler
    import led_seq_pkg::*;
#(
    parameter int PRESC_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                tick,
    output logic [PWM_BITS-1:0] pwm_cnt
);

    logic [PRESC_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count + PRESC_W'(1);
        end
    end

    assign tick    = &count;
    assign pwm_cnt = count[PWM_BITS-1:0];

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencing controller: accepts mode/rate/pattern over a valid/ready
// handshake and drives the LED bank in OFF, BLINK, CHASE or BREATHE mode,
// paced by a free-running prescaler.
// Build option: LED_SEQ_ACTIVE_LOW_EN inverts the led drive for active-low
// boards (reset/OFF value becomes all ones); internal state is unaffected.
// Parameters:
//   PRESC_W   - prescaler width, one tick every 2^PRESC_W clocks (min 4)
//   NUM_LED   - LED bank width
// Ports:
//   clk       - system clock
//   rst_n     - synchronous active-low reset
//   cfg       - configuration handshake (slave side)
//   led       - registered LED drive
//   busy      - high whenever the controller is not IDLE
//   step_tick - one-clock pulse in the cycle a pattern step shows on led
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | mode OFF, led held at 0, waiting for a configuration
// ST_APPLY | one cycle: load config, clear step_cnt/brightness, dir = up
// ST_RUN   | stepping the active mode; a new configuration re-enters APPLY
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int PRESC_W = 24,
    parameter int NUM_LED = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    led_seq_ctrl_if.slave      cfg,
    output logic [NUM_LED-1:0] led,
    output logic               busy,
    output logic               step_tick
);

    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;

    led_seq_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .pwm_cnt (pwm_cnt)
    );

    state_t state_q, state_d;

    // Captured at the transfer edge, committed during APPLY.
    mode_t              pend_mode_q;
    logic [RATE_W-1:0]  pend_rate_q;
    logic [NUM_LED-1:0] pend_pattern_q;

    mode_t              mode_q, mode_d;
    logic [RATE_W-1:0]  rate_q, rate_d;
    logic [NUM_LED-1:0] pattern_q, pattern_d;

    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic                dir_up_q, dir_up_d;
    logic [NUM_LED-1:0]  led_q, led_d;
    logic                step_tick_q;
    logic                step_fire;
    logic                hs;

    assign cfg.cfg_ready = (state_q != ST_APPLY);
    assign hs            = cfg.cfg_valid && (state_q != ST_APPLY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rate_d     = rate_q;
        pattern_d  = pattern_q;
        step_cnt_d = step_cnt_q;
        bright_d   = bright_q;
        dir_up_d   = dir_up_q;
        led_d      = led_q;
        step_fire  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                led_d = '0;
                if (hs) begin
                    state_d = ST_APPLY;
                end
            end

            ST_APPLY: begin
                mode_d     = pend_mode_q;
                rate_d     = pend_rate_q;
                pattern_d  = pend_pattern_q;
                step_cnt_d = '0;
                bright_d   = '0;
                dir_up_d   = 1'b1;
                if (pend_mode_q == MODE_BLINK || pend_mode_q == MODE_CHASE) begin
                    led_d = pend_pattern_q;
                end else begin
                    led_d = '0;
                end
                state_d = (pend_mode_q == MODE_OFF) ? ST_IDLE : ST_RUN;
            end

            ST_RUN: begin
                if (tick) begin
                    if (step_cnt_q == step_limit(rate_q)) begin
                        step_cnt_d = '0;
                        // A step landing in the handshake cycle would only
                        // become visible during APPLY, so it is dropped.
                        step_fire  = !hs;
                    end else begin
                        step_cnt_d = step_cnt_q + STEP_W'(1);
                    end
                end

                if (step_fire) begin
                    case (mode_q)
                        MODE_BLINK: begin
                            led_d = (led_q != '0) ? '0 : pattern_q;
                        end
                        MODE_CHASE: begin
                            led_d = {led_q[NUM_LED-2:0], led_q[NUM_LED-1]};
                        end
                        MODE_BREATHE: begin
                            // Triangle 0..15..0: flip direction on the step
                            // that lands on an end value.
                            if (dir_up_q) begin
                                bright_d = bright_q + PWM_BITS'(1);
                                if (bright_q == PWM_BITS'(14)) begin
                                    dir_up_d = 1'b0;
                                end
                            end else begin
                                bright_d = bright_q - PWM_BITS'(1);
                                if (bright_q == PWM_BITS'(1)) begin
                                    dir_up_d = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end

                // Breathe output is refreshed every clock from the PWM phase.
                if (mode_q == MODE_BREATHE) begin
                    led_d = (pwm_cnt < bright_q) ? pattern_q : '0;
                end

                if (hs) begin
                    state_d = ST_APPLY;
                end
            end

            default: begin
                state_d = ST_IDLE;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_mode_q    <= MODE_OFF;
            pend_rate_q    <= '0;
            pend_pattern_q <= '0;
            mode_q         <= MODE_OFF;
            rate_q         <= '0;
            pattern_q      <= '0;
            step_cnt_q     <= '0;
            bright_q       <= '0;
            dir_up_q       <= 1'b1;
            led_q          <= '0;
            step_tick_q    <= 1'b0;
        end else begin
            if (hs) begin
                pend_mode_q    <= mode_t'(cfg.cfg_mode);
                pend_rate_q    <= cfg.cfg_rate;
                pend_pattern_q <= cfg.cfg_pattern;
            end
            mode_q      <= mode_d;
            rate_q      <= rate_d;
            pattern_q   <= pattern_d;
            step_cnt_q  <= step_cnt_d;
            bright_q    <= bright_d;
            dir_up_q    <= dir_up_d;
            led_q       <= led_d;
            step_tick_q <= step_fire;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign step_tick = step_tick_q;

`ifdef LED_SEQ_ACTIVE_LOW_EN
    assign led = ~led_q;
`else
    assign led = led_q;
`endif

endmodule
